clock_divider_prog: RTL and testbench

- Fully synchronous, parametrised programmable clock divider. It replaces ripple-flop divider chains with a single-clock counter.
- Produces two outputs from `clk`:
  - a one-cycle enable pulse (`tick`) once per divide period, for downstream clock-enable use;
  - a near-50% square wave (`clkout`) for display and LED logic.
- The divisor is a runtime input. It is applied glitch-free at period boundaries, or immediately on a synchronous clear.
- Sits between the board clock and the display/counter blocks (e.g. seven-segment drivers).

---
 rtl/clock_divider_prog.sv | 91 +++++++++
 tb/tb_clock_divider_prog.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// Programmable single-clock divider: emits a one-cycle enable pulse and a
// near-50% square wave every div_active enabled cycles.
module clock_divider_prog #(
  parameter int unsigned WIDTH       = 25,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div,
  output logic             tick,
  output logic             clkout,
  output logic [WIDTH-1:0] phase,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_RESET =
    (DEFAULT_DIV < 32'd2) ? DIV_MIN : WIDTH'(DEFAULT_DIV);

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    if (x < DIV_MIN) begin
      r = DIV_MIN;
    end else begin
      r = x;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             clkout_q, clkout_d;
  logic             wrap_s;
  logic [WIDTH-1:0] half_s;
  logic [WIDTH-1:0] cnt_inc_s;

  assign wrap_s    = (cnt_q == (div_q - WIDTH'(1)));
  // High phase length is ceil(D/2), so odd divisors get the extra high cycle.
  assign half_s    = div_q - (div_q >> 1);
  assign cnt_inc_s = cnt_q + WIDTH'(1);

  // Next-state selection: clr beats en; divisor only reloads at wrap or clr.
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    clkout_d = clkout_q;
    tick_d   = 1'b0;
    if (clr) begin
      cnt_d    = '0;
      div_d    = clamp_div(div);
      clkout_d = 1'b1;
    end else if (en) begin
      if (wrap_s) begin
        cnt_d    = '0;
        div_d    = clamp_div(div);
        clkout_d = 1'b1;
        tick_d   = 1'b1;
      end else begin
        cnt_d    = cnt_inc_s;
        clkout_d = (cnt_inc_s < half_s);
      end
    end else begin
      cnt_d    = cnt_q;
      clkout_d = clkout_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= DIV_RESET;
      tick_q   <= 1'b0;
      clkout_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      clkout_q <= clkout_d;
    end
  end

  assign tick       = tick_q;
  assign clkout     = clkout_q;
  assign phase      = cnt_q;
  assign div_active = div_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed self-checking bench for clock_divider_prog (WIDTH=25, DEFAULT_DIV=4).
module tb_clock_divider_prog;

  localparam int unsigned WIDTH = 25;

  logic             clk;
  logic             rst;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] div;
  logic             tick;
  logic             clkout;
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] div_active;

  int n_vec;
  int n_miss;

  clock_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .div       (div),
    .tick      (tick),
    .clkout    (clkout),
    .phase     (phase),
    .div_active(div_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec = n_vec + 1;
    if (obs !== exp_v) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One rising edge, then settle away from the edge before sampling.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all(input string tag, input int ph, input int ck, input int tk, input int da);
    chk_vec({tag, ".phase"},  32'(phase),      32'(ph));
    chk_vec({tag, ".clkout"}, 32'(clkout),     32'(ck));
    chk_vec({tag, ".tick"},   32'(tick),       32'(tk));
    chk_vec({tag, ".div_act"},32'(div_active), 32'(da));
  endtask

  // Free run k edges of an already-loaded divisor d starting from phase 0.
  task automatic free_run(input string tag, input int d, input int k);
    int h;
    int p;
    h = d - d / 2;
    for (int i = 1; i <= k; i++) begin
      step();
      p = i % d;
      chk_all(tag, p, (p < h) ? 1 : 0, (p == 0) ? 1 : 0, d);
    end
  endtask

  task automatic clr_load(input logic [WIDTH-1:0] d);
    div = d;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  int exp_ck4 [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
  int exp_ph4 [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int exp_tk4 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int en_pat  [7] = '{1, 0, 0, 1, 1, 1, 0};
  int en_ph   [7] = '{1, 1, 1, 2, 3, 0, 0};
  int en_ck   [7] = '{1, 1, 1, 0, 0, 1, 1};
  int en_tk   [7] = '{0, 0, 0, 0, 0, 1, 0};
  int chg_ph  [10] = '{1, 2, 3, 0, 1, 2, 3, 4, 5, 0};
  int chg_ck  [10] = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  int chg_tk  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int chg_da  [10] = '{4, 4, 4, 6, 6, 6, 6, 6, 6, 6};
  logic [WIDTH-1:0] max_div;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1; en = 1'b1; clr = 1'b1; div = WIDTH'(9);

    // Reset wins over clr and en.
    step();
    step();
    chk_all("reset", 0, 0, 0, 4);

    // div=4 from reset: first tick on the 4th edge.
    clr = 1'b0;
    div = WIDTH'(4);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all("div4", exp_ph4[i], exp_ck4[i], exp_tk4[i], 4);
    end

    // div=5 free run: 3 high / 2 low, tick every 5.
    clr_load(WIDTH'(5));
    chk_all("clr5", 0, 1, 0, 5);
    free_run("div5", 5, 20);

    // div change 4->6 at phase 1 only lands on the wrap edge.
    clr_load(WIDTH'(4));
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) div = WIDTH'(6);
      chk_all("chg", chg_ph[i], chg_ck[i], chg_tk[i], chg_da[i]);
    end

    // div=0 and div=1 clamp to 2.
    clr_load(WIDTH'(0));
    chk_all("clr0", 0, 1, 0, 2);
    free_run("div0", 2, 6);
    clr_load(WIDTH'(1));
    chk_all("clr1", 0, 1, 0, 2);
    free_run("div1", 2, 4);

    // Enable gating with div=4.
    clr_load(WIDTH'(4));
    for (int i = 0; i < 7; i++) begin
      en = en_pat[i][0];
      step();
      chk_all("en", en_ph[i], en_ck[i], en_tk[i], 4);
    end
    en = 1'b1;

    // clr at phase 2 with div=3.
    clr_load(WIDTH'(3));
    step();
    step();
    chk_all("pre_clr", 2, 0, 0, 3);
    clr = 1'b1;
    step();
    chk_all("clr3", 0, 1, 0, 3);
    en = 1'b0;
    step();
    chk_all("clr_hold", 0, 1, 0, 3);

    // rst together with clr: reset values.
    en = 1'b1;
    div = WIDTH'(7);
    rst = 1'b1;
    step();
    chk_all("rst_clr", 0, 0, 0, 4);
    rst = 1'b0;
    clr = 1'b0;

    // Maximum divisor loads unclamped and counts without wrapping early.
    max_div = '1;
    clr_load(max_div);
    free_run("dmax", int'(max_div), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
